// File: rtl/i2s_clock_tdm.sv
// I2S/TDM bit-clock and frame generator: divides ck into sck/en, counts frame bit
// positions and drives word-select in I2S, I2S-with-lead or TDM-pulse framing.
module i2s_clock_tdm #(
    parameter int DIVIDER       = 12,
    parameter int BITS_PER_CHAN = 32,
    parameter int CHANNELS      = 2,
    localparam int FRAME        = BITS_PER_CHAN * CHANNELS,
    localparam int FW           = $clog2(FRAME),
    localparam int CW           = $clog2(CHANNELS),
    localparam int BW           = $clog2(BITS_PER_CHAN)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          run,
    input  logic [1:0]    mode,
    output logic          en,
    output logic          sck,
    output logic          ws,
    output logic [FW-1:0] frame_posn,
    output logic [CW-1:0] chan,
    output logic [BW-1:0] bit_posn,
    output logic          frame_start
);

    localparam int PW = $clog2(DIVIDER);
    localparam logic [PW-1:0] P_LAST = PW'(DIVIDER - 1);
    localparam logic [PW-1:0] P_HALF = PW'(DIVIDER / 2);
    localparam logic [FW-1:0] F_LAST = FW'(FRAME - 1);

    logic [PW-1:0] p_reg, p_next;
    logic [FW-1:0] f_reg, f_next;
    logic [1:0]    m_reg, m_next;
    logic          en_reg, en_next;
    logic          sck_reg, sck_next;
    logic          ws_reg, ws_next;
    logic          fs_reg, fs_next;
    logic [FW-1:0] f_inc;

    always_comb begin
        // FRAME is a power of two, so the increment wraps to 0 on its own
        f_inc    = f_reg + FW'(1);
        p_next   = p_reg;
        f_next   = f_reg;
        m_next   = m_reg;
        en_next  = 1'b0;
        sck_next = 1'b0;
        ws_next  = 1'b0;
        fs_next  = 1'b0;
        if (!run) begin
            p_next = '0;
            f_next = '0;
            m_next = mode;
        end else begin
            sck_next = (p_reg >= P_HALF);
            case (m_reg)
                2'd1:    ws_next = f_inc[FW-1];
                2'd2:    ws_next = (f_reg == '0);
                default: ws_next = f_reg[FW-1];
            endcase
            if (p_reg == P_LAST) begin
                p_next  = '0;
                f_next  = f_inc;
                en_next = 1'b1;
                fs_next = (f_reg == F_LAST);
                // framing mode only changes on a frame boundary
                if (f_reg == F_LAST) begin
                    m_next = mode;
                end
            end else begin
                p_next = p_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            p_reg   <= '0;
            f_reg   <= '0;
            m_reg   <= 2'd0;
            en_reg  <= 1'b0;
            sck_reg <= 1'b0;
            ws_reg  <= 1'b0;
            fs_reg  <= 1'b0;
        end else begin
            p_reg   <= p_next;
            f_reg   <= f_next;
            m_reg   <= m_next;
            en_reg  <= en_next;
            sck_reg <= sck_next;
            ws_reg  <= ws_next;
            fs_reg  <= fs_next;
        end
    end

    assign en          = en_reg;
    assign sck         = sck_reg;
    assign ws          = ws_reg;
    assign frame_posn  = f_reg;
    assign chan        = f_reg[FW-1:BW];
    assign bit_posn    = f_reg[BW-1:0];
    assign frame_start = fs_reg;

endmodule
